// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake and adder-side bus for nibble_serial_adder.
// NIBBLE_SERIAL_ADDER_SUB_EN adds the sub request bit.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int WIDTH = 4 * NIBBLES;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic [3:0]       add_r1;
    logic [3:0]       add_r2;
    logic             add_ci;
    logic [3:0]       add_sum;
    logic             add_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    modport slave (
        input  in_valid, a_in, b_in, cin, sub, add_sum, add_carry, out_ready,
        output in_ready, add_r1, add_r2, add_ci, out_valid, result, cout, ovf
    );
    modport master (
        output in_valid, a_in, b_in, cin, sub, add_sum, add_carry, out_ready,
        input  in_ready, add_r1, add_r2, add_ci, out_valid, result, cout, ovf
    );
`else
    modport slave (
        input  in_valid, a_in, b_in, cin, add_sum, add_carry, out_ready,
        output in_ready, add_r1, add_r2, add_ci, out_valid, result, cout, ovf
    );
    modport master (
        output in_valid, a_in, b_in, cin, add_sum, add_carry, out_ready,
        input  in_ready, add_r1, add_r2, add_ci, out_valid, result, cout, ovf
    );
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// Sequences a WIDTH-bit add through a shared 4-bit adder, LSB nibble first.
// Define NIBBLE_SERIAL_ADDER_SUB_EN to add the sub (A-B) request.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input logic                   clk,
    input logic                   rst,
    nibble_serial_adder_if.slave  bus
);
    localparam int WIDTH = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             cin_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] result_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             sub_reg;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic             b_msb;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_reg <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            sub_reg <= bus.sub;
        end
    end
`else
    assign sub_reg = 1'b0;
`endif

    // Subtraction adds the one's complement of B, so its sign flips too.
    assign b_msb = b_reg[WIDTH-1] ^ sub_reg;

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IDX_W'(n)) begin
                a_nib = a_reg[4*n +: 4];
                b_nib = b_reg[4*n +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.add_r1    = 4'h0;
        bus.add_r2    = 4'h0;
        bus.add_ci    = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                bus.add_r1 = a_nib;
                bus.add_r2 = sub_reg ? ~b_nib : b_nib;
                if (idx == '0) begin
                    bus.add_ci = sub_reg | cin_reg;
                end else begin
                    bus.add_ci = carry_reg;
                end
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            cin_reg    <= 1'b0;
            carry_reg  <= 1'b0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg   <= bus.a_in;
                        b_reg   <= bus.b_in;
                        cin_reg <= bus.cin;
                        idx     <= '0;
                    end
                end
                ADD: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (idx == IDX_W'(n)) begin
                            result_reg[4*n +: 4] <= bus.add_sum;
                        end
                    end
                    carry_reg <= bus.add_carry;
                    idx       <= idx + IDX_W'(1);
                    // Top nibble: its sum bit 3 is the result sign bit.
                    if (idx == LAST_IDX) begin
                        cout_reg <= bus.add_carry;
                        ovf_reg  <= (a_reg[WIDTH-1] == b_msb) &&
                                    (bus.add_sum[3] != a_reg[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_reg;
    assign bus.cout   = cout_reg;
    assign bus.ovf    = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4) with a behavioural 4-bit adder.
// Sub cases run only when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
module tb_nibble_serial_adder;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    nibble_serial_adder_if #(.NIBBLES(NIB)) bus ();

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Shared ripple adder outside the block.
    assign {bus.add_carry, bus.add_sum} = {1'b0, bus.add_r1} + {1'b0, bus.add_r2} + {4'b0, bus.add_ci};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        int   t;
        int   sa;
        int   sbv;
        int   ssum;
        int   usum;
        exp_t e;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            tick();
            t++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.cin      = c;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        bus.sub      = s;
`endif
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (s) begin
            ssum  = sa - sbv;
            usum  = int'(a) - int'(b);
            e.co  = (a >= b);
        end else begin
            ssum  = sa + sbv + int'(c);
            usum  = int'(a) + int'(b) + int'(c);
            e.co  = (usum > 65535);
        end
        e.res = usum[W-1:0];
        e.ov  = (ssum > 32767) || (ssum < -32768);
        sb.push_back(e);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic receive(input string name);
        int   t;
        exp_t e;
        bus.out_ready = 1'b1;
        t = 0;
        while (!bus.out_valid && t < 50) begin
            tick();
            t++;
        end
        total++;
        if (!bus.out_valid) begin
            bad++;
            $display("FAIL %s_timeout out_valid=%b required=1", name, bus.out_valid);
        end else if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s_unexpected out_valid=1 required=no pending op", name);
        end else begin
            e = sb.pop_front();
            if (bus.result !== e.res) begin
                bad++;
                $display("FAIL %s_result got=%h required=%h", name, bus.result, e.res);
            end
            total++;
            if (bus.cout !== e.co) begin
                bad++;
                $display("FAIL %s_cout got=%b required=%b", name, bus.cout, e.co);
            end
            total++;
            if (bus.ovf !== e.ov) begin
                bad++;
                $display("FAIL %s_ovf got=%b required=%b", name, bus.ovf, e.ov);
            end
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_release out_valid=%b in_ready=%b required=0/1", name, bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs in_ready=%b out_valid=%b required=1/0", bus.in_ready, bus.out_valid);
        end
        total++;
        if (bus.result !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_out result=%h cout=%b ovf=%b required=0000/0/0", bus.result, bus.cout, bus.ovf);
        end
        total++;
        if (bus.add_r1 !== 4'h0 || bus.add_r2 !== 4'h0 || bus.add_ci !== 1'b0) begin
            bad++;
            $display("FAIL reset_adder r1=%h r2=%h ci=%b required=0/0/0", bus.add_r1, bus.add_r2, bus.add_ci);
        end
    endtask

    task automatic test_carry_chain();
        logic [3:0] ci_seq;
        int         lat;
        ci_seq = 4'h0;
        lat    = 0;
        send(16'h0FFF, 16'h0001, 1'b0, 1'b0);
        total++;
        if (bus.in_ready !== 1'b0 || bus.add_r1 !== 4'hF || bus.add_r2 !== 4'h1) begin
            bad++;
            $display("FAIL chain_first in_ready=%b r1=%h r2=%h required=0/f/1", bus.in_ready, bus.add_r1, bus.add_r2);
        end
        while (!bus.out_valid && lat < 20) begin
            if (lat < 4) ci_seq[lat] = bus.add_ci;
            tick();
            lat++;
        end
        total++;
        if (lat !== NIB) begin
            bad++;
            $display("FAIL chain_latency edges=%0d required=%0d", lat, NIB);
        end
        total++;
        if (ci_seq !== 4'b1110) begin
            bad++;
            $display("FAIL chain_ci seq(msb=last)=%b required=1110", ci_seq);
        end
        receive("chain");
    endtask

    task automatic test_wrap();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        receive("wrap_ffff");
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        receive("ovf_pos");
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        receive("ovf_neg");
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        receive("wrap_cin");
    endtask

    task automatic test_backpressure();
        int t;
        send(16'h1234, 16'h4321, 1'b1, 1'b0);
        t = 0;
        while (!bus.out_valid && t < 20) begin
            tick();
            t++;
        end
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = k[0];
            bus.a_in     = 16'(k * 16'h0101);
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== sb[0].res) begin
                bad++;
                $display("FAIL hold_%0d out_valid=%b in_ready=%b result=%h required=1/0/%h",
                         k, bus.out_valid, bus.in_ready, bus.result, sb[0].res);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        receive("backpressure");
    endtask

    task automatic test_midop_reset();
        logic seen;
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_front());
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== '0) begin
            bad++;
            $display("FAIL midrst_state in_ready=%b out_valid=%b result=%h required=1/0/0000",
                     bus.in_ready, bus.out_valid, bus.result);
        end
        seen = 1'b0;
        for (int k = 0; k < NIB + 3; k++) begin
            if (bus.out_valid) seen = 1'b1;
            tick();
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL midrst_no_output out_valid_seen=%b required=0", seen);
        end
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        receive("midrst_retry");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        for (int k = 0; k < 8; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            c = 1'($urandom_range(0, 1));
            send(a, b, c, 1'b0);
            receive("b2b");
        end
    endtask

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        receive("sub_neg");
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        receive("sub_ovf");
        send(16'h0009, 16'h0003, 1'b1, 1'b1);
        receive("sub_cin_ignored");
        send(16'h0000, 16'h8000, 1'b0, 1'b1);
        receive("sub_ovf_min");
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.cin       = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        bus.sub       = 1'b0;
`endif
        tick();
        test_reset();
        test_carry_chain();
        test_wrap();
        test_backpressure();
        test_midop_reset();
        test_back_to_back();
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Sequencing stage directly upstream of the shared 4-bit ripple adder.
- Accepts two WIDTH-bit operands over a valid/ready handshake.
- Feeds the adder one nibble per clock, LSB nibble first, chaining the captured carry into the next nibble's carry input.
- Collects the per-nibble sums into a WIDTH-bit result with carry-out and signed-overflow flags, presented on a valid/ready output handshake.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand; WIDTH = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  single system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- cin  input  1  carry into nibble 0
- add_r1  output  4  to adder r1: current A nibble
- add_r2  output  4  to adder r2: current B nibble
- add_ci  output  1  to adder ci: chained carry
- add_sum  input  4  from adder sum (combinational, same cycle)
- add_carry  input  1  from adder carry (combinational, same cycle)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  assembled sum
- cout  output  1  carry out of the top nibble
- ovf  output  1  signed overflow of the WIDTH-bit add

Behaviour:
- Reset (rst high at a rising edge, any state):
  - state goes to IDLE; nibble index, a_reg, b_reg, carry_reg cleared.
  - result, cout, ovf, out_valid cleared to 0.
  - reset mid-operation aborts with no output.
  - in_ready is 1 in the first cycle after reset.
- States: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1; add_r1=0, add_r2=0, add_ci=0.
  - On in_valid&&in_ready: latch a_in, b_in, cin into registers; idx<=0; go to ADD.
- ADD (in_ready=0):
  - add_r1=a_reg[4*idx+:4], add_r2=b_reg[4*idx+:4].
  - add_ci=cin_reg when idx==0, else carry_reg.
  - Each edge: result[4*idx+:4]<=add_sum; carry_reg<=add_carry; idx<=idx+1.
  - When idx==NIBBLES-1:
    - cout<=add_carry.
    - ovf<=(a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (add_sum[3]!=a_reg[WIDTH-1]).
    - go to DONE.
- DONE:
  - out_valid=1; result, cout and ovf are held stable.
  - On out_ready: go to IDLE, out_valid drops the next cycle.
  - result is not cleared on leaving DONE; it holds until overwritten.
- Latency: operands accepted at edge T; out_valid is high in the cycle after edge T+NIBBLES. The result is therefore visible NIBBLES+1 cycles after the accept cycle.
- Throughput: one operation per NIBBLES+2 cycles minimum (accept, NIBBLES add cycles, DONE handshake).
- in_valid during ADD/DONE is ignored; the operands must be held by the producer until accepted.
- out_ready sampled only in DONE; out_ready high in other states has no effect.
- NIBBLES=1: a single ADD cycle, then DONE.
- Wrap-around: the sum is modulo 2^WIDTH; the carry out of the top nibble appears only on cout.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched with the operands at accept.
  - When sub_reg=1: add_r2 drives ~b_reg nibble, and nibble 0 add_ci is forced to 1 (cin ignored), giving A-B.
  - ovf uses the inverted B MSB.
  - cout=1 means no borrow.
- Not defined: no sub port; the block is addition only, behaving exactly as above.

Test Plan:
- Reset then idle: rst 1 cycle -> in_ready=1, out_valid=0, result=0x0000, cout=0, ovf=0, add_r1/add_r2/add_ci=0.
- Carry chain: a=0x0FFF, b=0x0001, cin=0 -> add_ci sequence 0,1,1,1; result=0x1000, cout=0, ovf=0; out_valid 5 cycles after accept.
- Full wrap and overflow:
  - a=0xFFFF, b=0x0001, cin=0 -> result=0x0000, cout=1, ovf=0.
  - a=0x7FFF, b=0x0001 -> result=0x8000, cout=0, ovf=1.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and result stay stable; in_valid pulses are ignored (in_ready=0); raise out_ready -> IDLE the next cycle.
- Mid-op reset: assert rst during the 2nd ADD cycle of a=0x1234, b=0x1111 -> IDLE, out_valid=0, result=0; a new add then completes correctly to 0x2345.
- SUB_EN build: sub=1, a=0x0005, b=0x0007 -> result=0xFFFE, cout=0; sub=1, a=0x8000, b=0x0001 -> result=0x7FFF, ovf=1.
